// File: rtl/mine_game_pkg.sv
// Shared types for the mine game blocks: FSM states, screen coordinates, lives width.
package mine_game_pkg;

  localparam int LIVES_W = 3;

  typedef logic signed [10:0] coord_t;

  typedef enum logic [2:0] {
    IDLE_ST,
    ARMED_ST,
    EXPLODE_ST,
    INVULN_ST,
    GAME_OVER_ST
  } state_t;

endpackage

// File: rtl/mine_hit_controller_frame_overlap_counter.sv
// Per-frame player/mine overlap pixel counter, saturating at 255.
// The registered count is the value accumulated up to (not including) the
// current cycle, so on a startOfFrame cycle it holds the finished frame's total.
module frame_overlap_counter (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       mineDrawingRequest,
  input  logic       playerDrawingRequest,
  output logic [7:0] overlap_cnt
);

  logic       overlap;
  logic [7:0] cnt_d, cnt_q;

  assign overlap     = mineDrawingRequest & playerDrawingRequest;
  assign overlap_cnt = cnt_q;

  // Reload on frame start (the sof pixel belongs to the new frame), else saturating count.
  always_comb begin
    cnt_d = cnt_q;
    if (startOfFrame)
      cnt_d = overlap ? 8'd1 : 8'd0;
    else if (overlap && cnt_q != 8'hFF)
      cnt_d = cnt_q + 8'd1;
  end

  // Count register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) cnt_q <= 8'd0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mine_hit_controller.sv
// Mine hit controller: once-per-frame overlap evaluation, lives bookkeeping,
// explosion sprite timing/position and sticky game-over.
module mine_hit_controller
  import mine_game_pkg::*;
#(
  parameter int LIVES_INIT     = 3,
  parameter int EXPLODE_FRAMES = 16,
  parameter int INVULN_FRAMES  = 60,
  parameter int MIN_HIT_PIXELS = 4
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               mineDrawingRequest,
  input  logic               playerDrawingRequest,
  input  coord_t             mineTopLeftX,
  input  coord_t             mineTopLeftY,
  output logic               explosionActive,
  output coord_t             explosionX,
  output coord_t             explosionY,
  output logic [LIVES_W-1:0] lives,
  output logic               playerHit,
  output logic               gameOver
);

  localparam logic [7:0]         MIN_HIT   = 8'(MIN_HIT_PIXELS);
  localparam logic [7:0]         EXPL_LEN  = 8'(EXPLODE_FRAMES);
  localparam logic [7:0]         INVL_LEN  = 8'(INVULN_FRAMES);
  localparam logic [LIVES_W-1:0] LIVES_RST = LIVES_W'(LIVES_INIT);

  logic [7:0]         overlap_cnt;
  state_t             state_d, state_q;
  logic [7:0]         frame_cnt_d, frame_cnt_q;
  logic [LIVES_W-1:0] lives_d, lives_q;
  coord_t             expl_x_d, expl_x_q, expl_y_d, expl_y_q;
  logic               hit_d, hit_q;
  logic               active_d, active_q;
  logic               game_over_d, game_over_q;

  frame_overlap_counter u_ovl (
    .clk                 (clk),
    .resetN              (resetN),
    .startOfFrame        (startOfFrame),
    .mineDrawingRequest  (mineDrawingRequest),
    .playerDrawingRequest(playerDrawingRequest),
    .overlap_cnt         (overlap_cnt)
  );

  // Next-state: everything moves only on startOfFrame; outputs derive from the next state.
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    lives_d     = lives_q;
    expl_x_d    = expl_x_q;
    expl_y_d    = expl_y_q;
    hit_d       = 1'b0;
    if (startOfFrame) begin
      unique case (state_q)
        IDLE_ST: state_d = ARMED_ST;   // partial first frame is thrown away
        ARMED_ST: begin
          if (overlap_cnt >= MIN_HIT) begin
            hit_d       = 1'b1;
            lives_d     = lives_q - LIVES_W'(1);
            expl_x_d    = mineTopLeftX;
            expl_y_d    = mineTopLeftY;
            frame_cnt_d = EXPL_LEN;
            state_d     = EXPLODE_ST;
          end
        end
        EXPLODE_ST: begin
          if (frame_cnt_q == 8'd1) begin
            if (lives_q == '0) begin
              state_d = GAME_OVER_ST;
            end else begin
              state_d     = INVULN_ST;
              frame_cnt_d = INVL_LEN;
            end
          end else begin
            frame_cnt_d = frame_cnt_q - 8'd1;
          end
        end
        INVULN_ST: begin
          if (frame_cnt_q == 8'd1) state_d = ARMED_ST;
          else                     frame_cnt_d = frame_cnt_q - 8'd1;
        end
        default: ;                     // game over is sticky
      endcase
    end
    active_d    = (state_d == EXPLODE_ST);
    game_over_d = (state_d == GAME_OVER_ST);
  end

  // State, timer, latches and registered outputs.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE_ST;
      frame_cnt_q <= 8'd0;
      lives_q     <= LIVES_RST;
      expl_x_q    <= '0;
      expl_y_q    <= '0;
      hit_q       <= 1'b0;
      active_q    <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      lives_q     <= lives_d;
      expl_x_q    <= expl_x_d;
      expl_y_q    <= expl_y_d;
      hit_q       <= hit_d;
      active_q    <= active_d;
      game_over_q <= game_over_d;
    end
  end

  assign explosionActive = active_q;
  assign explosionX      = expl_x_q;
  assign explosionY      = expl_y_q;
  assign lives           = lives_q;
  assign playerHit       = hit_q;
  assign gameOver        = game_over_q;

endmodule

// File: tb/tb_mine_hit_controller.sv
// Scoreboard bench for mine_hit_controller: stimulus pushes the expected
// post-startOfFrame output snapshot, the monitor pops and compares it.
module tb_mine_hit_controller;

  logic               clk = 1'b0;
  logic               resetN = 1'b0;
  logic               startOfFrame = 1'b0;
  logic               mdr = 1'b0, pdr = 1'b0;
  logic signed [10:0] mx = '0, my = '0;
  logic               explosionActive, playerHit, gameOver;
  logic signed [10:0] explosionX, explosionY;
  logic [2:0]         lives;

  typedef struct packed {
    logic               hit;
    logic               act;
    logic               go;
    logic [2:0]         lives;
    logic signed [10:0] x;
    logic signed [10:0] y;
  } exp_t;

  exp_t q[$];
  logic sample_req = 1'b0;
  logic done = 1'b0;
  int   n_tot = 0;
  int   n_pass = 0;

  mine_hit_controller dut (
    .clk                 (clk),
    .resetN              (resetN),
    .startOfFrame        (startOfFrame),
    .mineDrawingRequest  (mdr),
    .playerDrawingRequest(pdr),
    .mineTopLeftX        (mx),
    .mineTopLeftY        (my),
    .explosionActive     (explosionActive),
    .explosionX          (explosionX),
    .explosionY          (explosionY),
    .lives               (lives),
    .playerHit           (playerHit),
    .gameOver            (gameOver)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input bit h, input bit a, input bit g,
                              input int lv, input int x, input int y);
    exp_t e;
    e.hit = h; e.act = a; e.go = g;
    e.lives = lv[2:0]; e.x = x[10:0]; e.y = y[10:0];
    return e;
  endfunction

  // Monitor: compares the DUT against the oldest expected snapshot.
  always @(negedge clk) begin
    exp_t e;
    if (sample_req) begin
      n_tot++;
      if (q.size() == 0) begin
        $display("FAIL chk%0d: sample requested with empty scoreboard", n_tot);
      end else begin
        e = q.pop_front();
        if (playerHit !== e.hit || explosionActive !== e.act || gameOver !== e.go ||
            lives !== e.lives || explosionX !== e.x || explosionY !== e.y)
          $display("FAIL chk%0d: got hit=%0b act=%0b go=%0b lives=%0d x=%0d y=%0d, expected hit=%0b act=%0b go=%0b lives=%0d x=%0d y=%0d",
                   n_tot, playerHit, explosionActive, gameOver, lives,
                   $signed(explosionX), $signed(explosionY),
                   e.hit, e.act, e.go, e.lives, $signed(e.x), $signed(e.y));
        else
          n_pass++;
      end
    end
    if (done) begin
      n_tot++;
      if (q.size() != 0) $display("FAIL drain: %0d snapshots left, expected 0", q.size());
      else               n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Sample the current outputs once (used around reset).
  task automatic chk_now(input exp_t e);
    q.push_back(e); sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
  endtask

  // Frame boundary: e is expected the cycle after sof, then playerHit must drop.
  task automatic do_sof(input bit ov, input exp_t e);
    startOfFrame = 1'b1; mdr = ov; pdr = ov;
    tick();
    startOfFrame = 1'b0; mdr = 1'b0; pdr = 1'b0;
    q.push_back(e); sample_req = 1'b1;
    tick();
    e.hit = 1'b0; q.push_back(e);
    tick();
    sample_req = 1'b0;
  endtask

  // Frame body: n overlapping pixels plus a couple of mine-only pixels.
  task automatic frame(input int n);
    for (int i = 0; i < n; i++) begin mdr = 1'b1; pdr = 1'b1; tick(); end
    mdr = 1'b1; pdr = 1'b0; tick();
    mdr = 1'b0; tick();
  endtask

  // Full explosion with the mine wandering; the sprite must stay put.
  task automatic explode_seq(input int lv, input int x, input int y);
    for (int i = 1; i <= 15; i++) begin
      mx = 11'(x + i * 3); my = 11'(y - i);
      frame(5);
      do_sof(1'b0, mk(0, 1, 0, lv, x, y));
    end
    frame(5);
    if (lv == 0) do_sof(1'b0, mk(0, 0, 1, 0, x, y));
    else         do_sof(1'b0, mk(0, 0, 0, lv, x, y));
  endtask

  // Invulnerability: 60 frames of heavy overlap, none of them a hit.
  task automatic invuln_seq(input int lv, input int x, input int y);
    for (int i = 1; i <= 60; i++) begin
      frame(10);
      do_sof(1'b0, mk(0, 0, 0, lv, x, y));
    end
  endtask

  initial begin
    tick(); tick();
    chk_now(mk(0, 0, 0, 3, 0, 0));                 // reset state
    resetN = 1'b1;
    mx = 11'sd100; my = 11'sd50;
    frame(10);                                     // partial frame in IDLE, discarded
    do_sof(1'b0, mk(0, 0, 0, 3, 0, 0));
    frame(3);                                      // 3 < MIN_HIT_PIXELS
    do_sof(1'b1, mk(0, 0, 0, 3, 0, 0));            // sof pixel counts toward next frame
    frame(3);                                      // 1 + 3 = 4 -> hit
    do_sof(1'b0, mk(1, 1, 0, 2, 100, 50));
    explode_seq(2, 100, 50);
    invuln_seq(2, 100, 50);
    mx = 11'sd200; my = -11'sd30;
    frame(10);
    do_sof(1'b0, mk(1, 1, 0, 1, 200, -30));
    explode_seq(1, 200, -30);
    invuln_seq(1, 200, -30);
    mx = -11'sd5; my = 11'sd7;
    frame(4);
    do_sof(1'b0, mk(1, 1, 0, 0, -5, 7));
    explode_seq(0, -5, 7);                         // ends in game over
    for (int i = 0; i < 3; i++) begin
      frame(10);
      do_sof(1'b1, mk(0, 0, 1, 0, -5, 7));
    end
    // Reset in the middle of an explosion with frameCnt = 7.
    resetN = 1'b0; tick();
    resetN = 1'b1;
    mx = 11'sd30; my = 11'sd40;
    do_sof(1'b0, mk(0, 0, 0, 3, 0, 0));
    frame(4);
    do_sof(1'b0, mk(1, 1, 0, 2, 30, 40));
    for (int i = 0; i < 9; i++) begin
      frame(2);
      do_sof(1'b0, mk(0, 1, 0, 2, 30, 40));
    end
    mdr = 1'b1; pdr = 1'b1; tick();
    resetN = 1'b0;
    chk_now(mk(0, 0, 0, 3, 0, 0));
    resetN = 1'b1;
    frame(10);                                     // first sof after release: no evaluation
    do_sof(1'b0, mk(0, 0, 0, 3, 0, 0));
    frame(2);
    do_sof(1'b0, mk(0, 0, 0, 3, 0, 0));
    done = 1'b1;
  end

endmodule

// File: doc/mine_hit_controller.md
Name: mine_hit_controller

Overview:
- Sits directly downstream of the mine movement stage.
- Consumes the mine top-left position plus the per-pixel mine and player drawing requests.
- Detects player/mine overlap once per frame and manages lives, explosion and invulnerability timing.
- Drives the explosion sprite position/enable and the game-over flag toward the video mux and game control.

Parameters:
- LIVES_INIT, 3, lives after reset; legal range 1..7.
- EXPLODE_FRAMES, 16, frames the explosion stays visible; legal range 1..255.
- INVULN_FRAMES, 60, frames after an explosion during which hits are ignored; legal range 1..255.
- MIN_HIT_PIXELS, 4, overlapping pixels per frame needed to declare a hit; legal range 1..255.

Ports:
- clk  in  1  system clock; reset resetN, asynchronous, active-low; clock clk.
- resetN  in  1  asynchronous active-low reset.
- startOfFrame  in  1  one-cycle pulse at the start of each frame (30 Hz).
- mineDrawingRequest  in  1  mine pixel opaque at the current scan pixel.
- playerDrawingRequest  in  1  player pixel opaque at the current scan pixel.
- mineTopLeftX  in  11 signed  mine top-left X, from the mine mover.
- mineTopLeftY  in  11 signed  mine top-left Y, from the mine mover.
- explosionActive  out  1  explosion sprite enable.
- explosionX  out  11 signed  latched explosion top-left X.
- explosionY  out  11 signed  latched explosion top-left Y.
- lives  out  3  remaining lives.
- playerHit  out  1  one-cycle pulse per accepted hit.
- gameOver  out  1  sticky; set when lives reach 0 and the explosion has finished.

Behaviour:
- Reset values:
  - State IDLE_ST.
  - overlapCnt = 0, frameCnt = 0.
  - lives = LIVES_INIT.
  - explosionX = 0, explosionY = 0.
  - explosionActive = 0, playerHit = 0, gameOver = 0.
- Reset mid-operation aborts any state immediately; there is no residual pulse.
- overlapCnt (8 bit, saturating at 255):
  - Increments on each cycle where both drawing requests are 1.
  - On a startOfFrame cycle it reloads to 1 if overlap is present in that cycle, else 0.
  - Hit evaluation on that cycle uses the pre-reload registered value, so the startOfFrame-cycle pixel counts toward the next frame.
- All state transitions occur only on startOfFrame cycles. Outputs are registered: an effect is visible the cycle after that startOfFrame.
- IDLE_ST:
  - First startOfFrame → ARMED_ST.
  - The partial frame is discarded: overlapCnt reloads as above, with no evaluation.
- ARMED_ST:
  - On startOfFrame, if overlapCnt >= MIN_HIT_PIXELS, it is a hit:
    - playerHit = 1 for exactly one cycle.
    - lives decrements by 1.
    - explosionX/Y latch mineTopLeftX/Y sampled in that cycle.
    - frameCnt = EXPLODE_FRAMES.
    - → EXPLODE_ST.
  - Otherwise remain in ARMED_ST.
- EXPLODE_ST:
  - explosionActive = 1.
  - Hits are ignored; the counter still runs.
  - On startOfFrame:
    - If frameCnt == 1 and lives == 0 → GAME_OVER_ST.
    - If frameCnt == 1 and lives != 0 → INVULN_ST with frameCnt = INVULN_FRAMES.
    - Otherwise frameCnt decrements.
  - Result: explosionActive stays high for exactly EXPLODE_FRAMES frames.
- INVULN_ST:
  - Hits are ignored.
  - On startOfFrame: if frameCnt == 1 → ARMED_ST, else frameCnt decrements.
  - Overlap in the frame that ends on the exit startOfFrame is not evaluated.
- GAME_OVER_ST:
  - gameOver = 1, explosionActive = 0, lives = 0.
  - Sticky until reset; all inputs are ignored.
- Lives never underflow: the decrement occurs only in ARMED_ST, where lives >= 1.
- explosionX/Y hold their last latched value outside EXPLODE_ST.
- Position inputs are used only at the hit instant; the mine's position changing during an explosion does not move the explosion.

Decomposition:
- Shared package mine_game_pkg holds:
  - The state enum (IDLE_ST, ARMED_ST, EXPLODE_ST, INVULN_ST, GAME_OVER_ST).
  - The 11-bit signed coordinate typedef.
  - The LIVES_W = 3 constant.
- One sub-module is natural: frame_overlap_counter, which contains the saturating per-frame pixel counter and the registered count output for startOfFrame evaluation.
- The FSM, timers and latches remain in the top.

Test Plan:
- Reset, then sof, then a frame with 10 overlap pixels → at the next sof: playerHit pulses for 1 cycle, lives 3→2, explosionActive = 1, explosionX/Y = mine position at that sof.
- A frame with only 3 overlap pixels in ARMED_ST (MIN_HIT_PIXELS = 4) → no playerHit, lives stay 3.
- After a hit, count frames → explosionActive is high for exactly 16 sof intervals; then 60 frames of continuous overlap produce no hit; in the 1st ARMED frame with overlap >= 4, a hit fires at the next sof.
- Three hits spaced past invulnerability → lives 3→2→1→0; after the 16-frame explosion gameOver = 1, explosionActive = 0; further overlap is ignored.
- Overlap pixel exactly on the sof cycle plus 3 more in the following frame → a hit is counted (total 4) at the next sof.
- Assert resetN mid-EXPLODE_ST (frameCnt = 7) → the next cycle shows explosionActive = 0, lives = 3, IDLE_ST; the first sof after release does not evaluate overlap.
